// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small FIFO in front of the line.
// The producer pushes bytes through a valid/ready handshake.
// Frames are 8N1-style and sent LSB first, with STOP_BITS stop bits.
// While the FIFO holds data, frames go out back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BIT_RATE     = 256000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CPB      = CLK_HZ / BIT_RATE;
    localparam int unsigned STOP_CYC = STOP_BITS * CPB;
    localparam int unsigned CYC_W    = (STOP_CYC > 1) ? $clog2(STOP_CYC) : 1;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned BIT_W    = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    // Reject parameter sets the datapath cannot handle.
    if (CPB < 2) begin : g_cpb_check
        $error("uart_tx_fifo: CLK_HZ / BIT_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_stop_check
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FSM / shifter state
    state_t                  state_q, state_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic                    txd_q, txd_d;

    // FIFO state
    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    push;
    logic                    pop;

    assign push = tx_valid && ready_q;

    // Next-state logic for the line FSM, including the FIFO pop decision.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shreg_d = mem[rd_ptr_q];
                    txd_d   = 1'b0;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cyc_q == CYC_W'(CPB - 1)) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    txd_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            S_DATA: begin
                if (cyc_q == CYC_W'(CPB - 1)) begin
                    cyc_d = '0;
                    if (bit_q == BIT_W'(PAYLOAD_BITS - 1)) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        txd_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            S_STOP: begin
                if (cyc_q == CYC_W'(STOP_CYC - 1)) begin
                    cyc_d = '0;
                    if (count_q != '0) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shreg_d = mem[rd_ptr_q];
                        txd_d   = 1'b0;
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            default: begin
                txd_d   = 1'b1;
                cyc_d   = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy and registered status flags derived from next-cycle values.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d  = (state_d != S_IDLE) || (count_d != '0);
    end

    // Line FSM and shifter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

    // FIFO pointers, count and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign uart_txd   = txd_q;
    assign tx_ready   = ready_q;
    assign tx_busy    = busy_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue/frame-offset model is checked every cycle,
// plus directed scenarios with hand-computed expected waveforms.
module tb_uart_tx_fifo;

    localparam int CPB = 10;
    localparam int FL  = 100;   // (1 + 8 + 1) * CPB

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    logic [7:0] tx_data2 = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2;
    logic       uart_txd2;
    logic       tx_busy2;
    logic [2:0] fifo_count2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_txd(uart_txd), .tx_busy(tx_busy),
        .fifo_count(fifo_count));

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .uart_txd(uart_txd2), .tx_busy(tx_busy2),
        .fifo_count(fifo_count2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level at a given offset into a one-stop-bit frame carrying b.
    function automatic logic line_of(input logic [7:0] b, input int off);
        int s;
        s = off / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
        return 1'b1;
    endfunction

    // Behavioural model: a byte queue plus the offset into the current frame.
    logic [7:0] mq[$];
    bit         m_in = 1'b0;
    int         m_off = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_push;
    logic [7:0] m_data;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_in  = 1'b0;
                m_off = 0;
            end else begin
                m_push = tx_valid && (mq.size() < 4);
                m_data = tx_data;
                if (m_in && (m_off < FL - 1)) begin
                    m_off++;
                end else if (mq.size() != 0) begin
                    m_cur = mq.pop_front();
                    m_in  = 1'b1;
                    m_off = 0;
                end else begin
                    m_in = 1'b0;
                end
                if (m_push) mq.push_back(m_data);
            end
        end
    end

    // Per-cycle comparison of the main DUT against the model.
    initial begin
        logic exp_txd;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_txd = m_in ? line_of(m_cur, m_off) : 1'b1;
                check("model_txd", 32'(uart_txd), 32'(exp_txd));
                check("model_count", 32'(fifo_count), 32'(mq.size()));
                check("model_ready", 32'(tx_ready), 32'(mq.size() != 4));
                check("model_busy", 32'(tx_busy), 32'(m_in || (mq.size() != 0)));
            end
        end
    end

    // Mid-bit sampling decoder on the main DUT line.
    logic [7:0] dec_q[$];
    logic [7:0] dec_b = 8'h00;
    int         dec_pos = -1;

    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dec_pos = -1;
            end else if (dec_pos < 0) begin
                if (uart_txd == 1'b0) dec_pos = 0;
            end else begin
                dec_pos++;
                if ((dec_pos % CPB) == (CPB / 2)) begin
                    s = dec_pos / CPB;
                    if (s >= 1 && s <= 8) begin
                        dec_b[s-1] = uart_txd;
                    end else if (s == 9) begin
                        check("dec_stop", 32'(uart_txd), 32'd1);
                        dec_q.push_back(dec_b);
                        dec_pos = -1;
                    end
                end
            end
        end
    end

    logic line_s[0:255];
    logic busy_s[0:255];

    // Directed scenarios.
    initial begin
        logic [9:0] vec;
        logic [9:0] exp10;
        logic [7:0] b4[6];
        int         acc[6];
        int         i;
        int         c;
        int         acc_at_fall;
        bit         fell;
        bit         rdy;
        int         f;
        int         sl;
        logic       e;

        b4[0] = 8'h11; b4[1] = 8'h82; b4[2] = 8'h3C;
        b4[3] = 8'hE7; b4[4] = 8'h49; b4[5] = 8'hD0;
        for (int k = 0; k < 6; k++) acc[k] = -1;

        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1;
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0xA5.
        dec_q.delete();
        tx_data = 8'hA5; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        check("t2_count_after_push", 32'(fifo_count), 32'd1);
        check("t2_busy_after_push", 32'(tx_busy), 32'd1);
        check("t2_txd_after_push", 32'(uart_txd), 32'd1);
        for (int k = 0; k < 102; k++) begin
            @(negedge clk);
            line_s[k] = uart_txd;
            busy_s[k] = tx_busy;
        end
        exp10 = {1'b1, 8'hA5, 1'b0};
        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < 10; j++) vec[j] = line_s[s * 10 + j];
            check($sformatf("t2_slot%0d", s), 32'(vec), exp10[s] ? 32'h3FF : 32'h000);
        end
        check("t2_busy_last", 32'(busy_s[99]), 32'd1);
        check("t2_busy_fall", 32'(busy_s[100]), 32'd0);
        check("t2_idle_line", 32'(line_s[100]), 32'd1);
        check("t2_dec_n", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() >= 1) check("t2_dec0", 32'(dec_q[0]), 32'hA5);

        // Back-to-back 0x55, 0x0F.
        repeat (5) @(negedge clk);
        dec_q.delete();
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk); tx_data = 8'h0F;
        @(negedge clk); tx_valid = 1'b0;
        for (int k = 0; k < 201; k++) begin
            line_s[k] = uart_txd;
            busy_s[k] = tx_busy;
            @(negedge clk);
        end
        check("t3_start1", 32'(line_s[0]), 32'd0);
        check("t3_stop1_last", 32'(line_s[99]), 32'd1);
        check("t3_start2", 32'(line_s[100]), 32'd0);
        check("t3_busy_last", 32'(busy_s[199]), 32'd1);
        check("t3_busy_fall", 32'(busy_s[200]), 32'd0);
        check("t3_dec_n", 32'(dec_q.size()), 32'd2);
        if (dec_q.size() >= 2) begin
            check("t3_dec0", 32'(dec_q[0]), 32'h55);
            check("t3_dec1", 32'(dec_q[1]), 32'h0F);
        end

        // Full FIFO with tx_valid held high.
        repeat (5) @(negedge clk);
        dec_q.delete();
        i = 0; c = 0; fell = 1'b0; acc_at_fall = -1;
        tx_valid = 1'b1; tx_data = b4[0];
        while (i < 6 && c < 400) begin
            rdy = tx_ready;
            @(posedge clk);
            if (rdy) begin
                acc[i] = c;
                i++;
            end
            c++;
            @(negedge clk);
            if (!tx_ready && !fell) begin
                fell = 1'b1;
                acc_at_fall = i;
                check("t4_count_full", 32'(fifo_count), 32'd4);
            end
            if (i < 6) tx_data = b4[i];
            else tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        check("t4_all_accepted", 32'(i), 32'd6);
        check("t4_accepted_at_fall", 32'(acc_at_fall), 32'd5);
        check("t4_fifth_cycle", 32'(acc[4]), 32'd4);
        check("t4_sixth_cycle", 32'(acc[5]), 32'd102);
        repeat (540) @(negedge clk);
        check("t4_dec_n", 32'(dec_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < dec_q.size()) check($sformatf("t4_dec%0d", k), 32'(dec_q[k]), 32'(b4[k]));
        end

        // Reset during data bit 3 with two bytes queued.
        repeat (5) @(negedge clk);
        dec_q.delete();
        tx_data = 8'hC3; tx_valid = 1'b1;
        @(negedge clk); tx_data = 8'h5A;
        @(negedge clk); tx_data = 8'h96;
        @(negedge clk); tx_valid = 1'b0;
        check("t5_count_queued", 32'(fifo_count), 32'd2);
        repeat (43) @(negedge clk);
        check("t5_bit3_before_rst", 32'(uart_txd), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_txd", 32'(uart_txd), 32'd1);
        check("t5_rst_count", 32'(fifo_count), 32'd0);
        check("t5_rst_ready", 32'(tx_ready), 32'd1);
        check("t5_rst_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("t5_no_frames", 32'(dec_q.size()), 32'd0);
        check("t5_idle_txd", 32'(uart_txd), 32'd1);
        check("t5_idle_busy", 32'(tx_busy), 32'd0);
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        for (int k = 0; k < 102; k++) begin
            @(negedge clk);
            line_s[k] = uart_txd;
            busy_s[k] = tx_busy;
        end
        check("t5_start", 32'(line_s[0]), 32'd0);
        check("t5_busy_last", 32'(busy_s[99]), 32'd1);
        check("t5_busy_fall", 32'(busy_s[100]), 32'd0);
        check("t5_dec_n", 32'(dec_q.size()), 32'd1);
        if (dec_q.size() >= 1) check("t5_dec0", 32'(dec_q[0]), 32'h3C);

        // Two stop bits: 0xFF then 0x00.
        repeat (5) @(negedge clk);
        tx_data2 = 8'hFF; tx_valid2 = 1'b1;
        @(negedge clk); tx_data2 = 8'h00;
        @(negedge clk); tx_valid2 = 1'b0;
        for (int k = 0; k < 221; k++) begin
            line_s[k] = uart_txd2;
            busy_s[k] = tx_busy2;
            @(negedge clk);
        end
        for (int k = 0; k < 221; k++) begin
            f  = k / 110;
            sl = (k % 110) / 10;
            if (f >= 2)       e = 1'b1;
            else if (sl == 0) e = 1'b0;
            else if (sl <= 8) e = (f == 0);
            else              e = 1'b1;
            check($sformatf("t6_line%0d", k), 32'(line_s[k]), 32'(e));
        end
        check("t6_stop_first", 32'(line_s[90]), 32'd1);
        check("t6_stop_last", 32'(line_s[109]), 32'd1);
        check("t6_start2", 32'(line_s[110]), 32'd0);
        check("t6_busy_last", 32'(busy_s[219]), 32'd1);
        check("t6_busy_fall", 32'(busy_s[220]), 32'd0);
        check("t6_count_end", 32'(fifo_count2), 32'd0);
        check("t6_ready_end", 32'(tx_ready2), 32'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
